sync_fifo_param: RTL
====================

# sync_fifo_param

Single-clock, parametrised synchronous FIFO for intra-domain buffering in the GreenRio2 peripheral subsystem (UART/SPI/DMA staging). It is the single-clock successor of the dual-clock FIFO: any depth from 2 to 256, not only powers of two. It adds programmable almost-full and almost-empty thresholds, a live occupancy count, synchronous flush, and optional overflow/underflow error capture.

## Interface
- W, 8: data width in bits, 1..64.
- DP, 4: depth in entries, 2..256; any integer.
- AW, derived ceil(log2(DP)): pointer width. Count width is AW+1.
- AFULL_TH, DP-1: afull asserts when count >= AFULL_TH; range 1..DP.
- AEMPTY_TH, 1: aempty asserts when count <= AEMPTY_TH; range 0..DP-1.
- RD_FAST, 1: 1 = first-word-fall-through combinational output; 0 = registered output.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous clear of pointers and count.
- wr_en  in  1  write request.
- wr_data  in  W  write data.
- rd_en  in  1  read request.
- rd_data  out  W  read data.
- rd_valid  out  1  rd_data qualifier.
- full  out  1  count == DP.
- afull  out  1  count >= AFULL_TH.
- empty  out  1  count == 0.
- aempty  out  1  count <= AEMPTY_TH.
- count  out  AW+1  current occupancy, 0..DP.
- overflow  out  1  sticky flag: write dropped.
- underflow  out  1  sticky flag: read dropped.
- err_clr  in  1  clears the sticky flags.

## Operation
- Storage: DP x W register array; not reset.
- Pointers wr_ptr and rd_ptr are AW bits wide. On increment, a pointer at DP-1 wraps to 0, with no power-of-two assumption.
- count is a registered AW+1-bit value. It changes by +1 on a write-only, -1 on a read-only, and 0 on a simultaneous accepted read and write.
- Write acceptance: wr_acc = wr_en & ~full & ~flush. full is the registered-state flag at the start of the cycle.
  - A write while full is dropped, even if a read is accepted in the same cycle.
- Read acceptance: rd_acc = rd_en & ~empty & ~flush.
  - A read while empty is dropped, even with a simultaneous write.
- Flags are decoded combinationally from count only, so they never glitch on wr_en/rd_en.
- RD_FAST=1:
  - rd_data = mem[rd_ptr] combinationally.
  - rd_valid = ~empty.
  - rd_en acts as a pop/acknowledge.
- RD_FAST=0:
  - On rd_acc, rd_data_q <= mem[rd_ptr] and rd_valid <= 1.
  - Otherwise rd_valid <= 0 and rd_data_q holds its value.
- flush: wr_ptr, rd_ptr and count go to 0; rd_valid goes to 0; memory contents are kept. flush has priority over wr_en and rd_en in the same cycle. Sticky flags are not affected.
- reset_n=0 at the clock edge: all state is cleared regardless of other inputs, including in the middle of a burst.

## Timing
- Write-to-read latency: a word written at edge N is visible on rd_data with rd_valid=1 in cycle N+1 (RD_FAST=1). With RD_FAST=0, it is presented one cycle after the accepting rd_en edge.
- Flags and count update in the cycle after the accepting edge.
- Reset values: empty=1, aempty=1, full=0, count=0, rd_valid=0, rd_data=0 (RD_FAST=0; with RD_FAST=1 it is memory content, don't-care), overflow=0, underflow=0.
- afull reset value: 0 when AFULL_TH >= 1.
- Full back-to-back throughput is one write and one read per cycle.

## Configuration
- SYNC_FIFO_ERR_CHK_EN defined:
  - overflow sets on (wr_en & full & ~flush).
  - underflow sets on (rd_en & empty & ~flush).
  - Both hold until err_clr=1 or reset. If err_clr and a set event occur in the same cycle, the set wins.
- SYNC_FIFO_ERR_CHK_EN undefined:
  - overflow and underflow are tied to 0 and err_clr is ignored.
  - Drop behaviour on full/empty is identical in both builds.

## Test plan
- DP=5, RD_FAST=1: write 5 words 0xA0..0xA4 -> full=1 and count=5 after the 5th edge. A 6th write is dropped; count stays 5. Reads return 0xA0..0xA4 in order, then empty=1.
- DP=5: interleave 12 writes and reads so pointers wrap twice -> data order preserved, count never exceeds 5, pointers return to index 0 after index 4.
- DP=8, AFULL_TH=6, AEMPTY_TH=2: fill one word at a time -> aempty=1 at counts 0..2, afull=1 from count 6, full only at 8.
- Full FIFO with simultaneous wr_en and rd_en -> read accepted, write dropped, count becomes DP-1. With ERR_CHK_EN defined, overflow=1 until err_clr is pulsed.
- RD_FAST=0: write 0x3C then pulse rd_en -> rd_valid=1 and rd_data=0x3C exactly one cycle later; rd_valid returns to 0 the next cycle.
- Load 3 words, then assert flush together with wr_en -> count=0, empty=1, no write accepted. A subsequent reset_n low for one edge leaves all outputs at their reset values.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO for any depth 2..256, with programmable almost-full/almost-empty and a live count.
// Define SYNC_FIFO_ERR_CHK_EN to build the sticky overflow/underflow capture.
module sync_fifo_param #(
  parameter int W         = 8,
  parameter int DP        = 4,
  parameter int AW        = (DP > 1) ? $clog2(DP) : 1,
  parameter int AFULL_TH  = DP - 1,
  parameter int AEMPTY_TH = 1,
  parameter int RD_FAST   = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid,
  output logic          full,
  output logic          afull,
  output logic          empty,
  output logic          aempty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow,
  input  logic          err_clr
);

  localparam logic [AW:0]   DP_C   = (AW+1)'(DP);
  localparam logic [AW:0]   AF_C   = (AW+1)'(AFULL_TH);
  localparam logic [AW:0]   AE_C   = (AW+1)'(AEMPTY_TH);
  localparam logic [AW-1:0] PTR_MX = AW'(DP - 1);

  logic [W-1:0]  mem [DP];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt_q;
  logic          wr_acc, rd_acc;

  // Explicit wrap at DP-1 so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_MX) ? '0 : p + AW'(1);
  endfunction

  assign full   = (cnt_q == DP_C);
  assign empty  = (cnt_q == '0);
  assign afull  = (cnt_q >= AF_C);
  assign aempty = (cnt_q <= AE_C);
  assign count  = cnt_q;

  assign wr_acc = wr_en & ~full  & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  generate
    if (RD_FAST != 0) begin : g_fwft
      assign rd_data  = mem[rd_ptr];
      assign rd_valid = ~empty;
    end else begin : g_reg
      logic [W-1:0] rd_data_q;
      logic         rd_valid_q;
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= mem[rd_ptr];
        end
      end
      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

`ifdef SYNC_FIFO_ERR_CHK_EN
  logic ovf_q, unf_q;
  // Set beats clear when both happen in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_en & full & ~flush) ovf_q <= 1'b1;
      else if (err_clr)          ovf_q <= 1'b0;
      if (rd_en & empty & ~flush) unf_q <= 1'b1;
      else if (err_clr)           unf_q <= 1'b0;
    end
  end
  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  logic err_clr_unused;
  assign err_clr_unused = err_clr;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
